// File: rtl/noc_parameters.sv
// Shared definitions for the NI initiator packetizer: header field layout,
// command encodings, FSM states and the burst-length normalisation helper.
package noc_parameters;

  // Header flit 0 field offsets (LSB positions) and fixed-width fields
  localparam int HDR_PATH_LSB  = 0;
  localparam int HDR_TGT_LSB   = 7;
  localparam int HDR_SRC_LSB   = 11;
  localparam int HDR_CMD_LSB   = 15;
  localparam int HDR_CMD_W     = 3;
  localparam int HDR_BURST_LSB = 18;
  localparam int HDR_BURST_W   = 8;

  // Request command encodings; any other code is forwarded untouched
  localparam logic [2:0] CMD_WRITE = 3'd1;
  localparam logic [2:0] CMD_READ  = 3'd2;

  // Packetizer FSM states
  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    HDR0,
    HDR1,
    DATA,
    DRAIN,
    ERR
  } state_t;

  // A burst length of zero means a single beat
  function automatic logic [7:0] normBurst(input logic [7:0] burst);
    return (burst == 8'd0) ? 8'd1 : burst;
  endfunction

endpackage

// File: rtl/ni_header_builder.sv
// Packs the registered request fields into the two header flits.
module ni_header_builder
  import noc_parameters::*;
#(
  parameter int FLIT_WIDTH = 32,
  parameter int PATH_WIDTH = 7,
  parameter int TGT_WIDTH  = 4
) (
  input  logic [PATH_WIDTH-1:0] i_path,
  input  logic [TGT_WIDTH-1:0]  i_tgt,
  input  logic [TGT_WIDTH-1:0]  i_src,
  input  logic [2:0]            i_cmd,
  input  logic [7:0]            i_burst,
  input  logic [31:0]           i_addr,
  output logic [FLIT_WIDTH-1:0] o_hdr0,
  output logic [FLIT_WIDTH-1:0] o_hdr1
);

  // Route, target, source, command and burst packed LSB first, upper bits zero
  always_comb begin
    o_hdr0 = '0;
    o_hdr0[HDR_PATH_LSB  +: PATH_WIDTH]  = i_path;
    o_hdr0[HDR_TGT_LSB   +: TGT_WIDTH]   = i_tgt;
    o_hdr0[HDR_SRC_LSB   +: TGT_WIDTH]   = i_src;
    o_hdr0[HDR_CMD_LSB   +: HDR_CMD_W]   = i_cmd;
    o_hdr0[HDR_BURST_LSB +: HDR_BURST_W] = i_burst;
  end

  assign o_hdr1 = FLIT_WIDTH'(i_addr);

endmodule

// File: rtl/ni_initiator_packetizer.sv
// Turns one OCP-style request into a two-flit header plus write-data flits,
// or drains the request and raises an error response when the address fails
// to decode. One transaction in flight at a time.
module ni_initiator_packetizer
  import noc_parameters::*;
#(
  parameter int          FLIT_WIDTH = 32,
  parameter int          PATH_WIDTH = 7,
  parameter int          TGT_WIDTH  = 4,
  parameter int unsigned SRC_ID     = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  input  logic [2:0]            req_cmd,
  input  logic [7:0]            req_burst,
  input  logic [FLIT_WIDTH-1:0] wdata,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  output logic [31:0]           lut_address,
  input  logic [PATH_WIDTH-1:0] lut_path,
  input  logic [TGT_WIDTH-1:0]  transaction_target,
  input  logic                  failed_decoding,
  output logic [FLIT_WIDTH-1:0] flit_out,
  output logic                  flit_valid,
  input  logic                  flit_ready,
  output logic                  flit_last,
  output logic                  err_valid,
  input  logic                  err_ready,
  output logic [2:0]            err_cmd
);

  state_t                r_state;
  state_t                w_nextState;
  logic [31:0]           r_addr;
  logic [2:0]            r_cmd;
  logic [7:0]            r_burst;
  logic [TGT_WIDTH-1:0]  r_src;
  logic [PATH_WIDTH-1:0] r_path;
  logic [TGT_WIDTH-1:0]  r_tgt;
  logic [7:0]            r_count;
  logic                  w_isWrite;
  logic                  w_beat;
  logic                  w_lastBeat;
  logic [FLIT_WIDTH-1:0] w_hdr0;
  logic [FLIT_WIDTH-1:0] w_hdr1;

  assign w_isWrite   = (r_cmd == CMD_WRITE);
  assign w_beat      = ((r_state == DATA) && wdata_valid && flit_ready) ||
                       ((r_state == DRAIN) && wdata_valid);
  assign w_lastBeat  = w_beat && (r_count == 8'd1);
  assign lut_address = r_addr;

  ni_header_builder #(
    .FLIT_WIDTH (FLIT_WIDTH),
    .PATH_WIDTH (PATH_WIDTH),
    .TGT_WIDTH  (TGT_WIDTH)
  ) u_headerBuilder (
    .i_path  (r_path),
    .i_tgt   (r_tgt),
    .i_src   (r_src),
    .i_cmd   (r_cmd),
    .i_burst (r_burst),
    .i_addr  (r_addr),
    .o_hdr0  (w_hdr0),
    .o_hdr1  (w_hdr1)
  );

  // State register; reset abandons any partial packet
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Next-state selection from handshakes and the lookup result
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (req_valid) w_nextState = LOOKUP;
      LOOKUP:  if (failed_decoding) w_nextState = w_isWrite ? DRAIN : ERR;
               else                 w_nextState = HDR0;
      HDR0:    if (flit_ready) w_nextState = HDR1;
      HDR1:    if (flit_ready) w_nextState = w_isWrite ? DATA : IDLE;
      DATA:    if (w_lastBeat) w_nextState = IDLE;
      DRAIN:   if (w_lastBeat) w_nextState = ERR;
      ERR:     if (err_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Output decode; header flits depend only on state so they hold under stall
  always_comb begin
    req_ready   = 1'b0;
    flit_out    = '0;
    flit_valid  = 1'b0;
    flit_last   = 1'b0;
    wdata_ready = 1'b0;
    err_valid   = 1'b0;
    err_cmd     = 3'd0;
    unique case (r_state)
      IDLE:  req_ready = 1'b1;
      HDR0: begin
        flit_out   = w_hdr0;
        flit_valid = 1'b1;
      end
      HDR1: begin
        flit_out   = w_hdr1;
        flit_valid = 1'b1;
        flit_last  = !w_isWrite;
      end
      DATA: begin
        flit_out    = wdata;
        flit_valid  = wdata_valid;
        wdata_ready = flit_ready;
        flit_last   = (r_count == 8'd1);
      end
      DRAIN: wdata_ready = 1'b1;
      ERR: begin
        err_valid = 1'b1;
        err_cmd   = r_cmd;
      end
      default: ;
    endcase
  end

  // Request capture, lookup sampling and the beat counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr  <= '0;
      r_cmd   <= '0;
      r_burst <= '0;
      r_src   <= '0;
      r_path  <= '0;
      r_tgt   <= '0;
      r_count <= '0;
    end else begin
      if ((r_state == IDLE) && req_valid) begin
        r_addr  <= req_addr;
        r_cmd   <= req_cmd;
        r_burst <= normBurst(req_burst);
        r_src   <= TGT_WIDTH'(SRC_ID);
      end
      if (r_state == LOOKUP) begin
        r_path  <= lut_path;
        r_tgt   <= transaction_target;
        r_count <= r_burst;
      end else if (w_beat && (r_count != 8'd1)) begin
        r_count <= r_count - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ni_initiator_packetizer.sv
// Self-checking bench for the NI initiator packetizer: directed scenarios
// followed by randomized transactions with random backpressure, checked
// against a packet-level model of the expected flit stream.
module tb_ni_initiator_packetizer;

  localparam int         MAXC = 300;
  localparam logic [3:0] SRC  = 4'h0;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_cmd;
  logic [7:0]  req_burst;
  logic [31:0] wdata;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [31:0] lut_address;
  logic [6:0]  lut_path;
  logic [3:0]  transaction_target;
  logic        failed_decoding;
  logic [31:0] flit_out;
  logic        flit_valid;
  logic        flit_ready;
  logic        flit_last;
  logic        err_valid;
  logic        err_ready;
  logic [2:0]  err_cmd;

  int compared   = 0;
  int mismatched = 0;

  ni_initiator_packetizer #(
    .FLIT_WIDTH (32),
    .PATH_WIDTH (7),
    .TGT_WIDTH  (4),
    .SRC_ID     (0)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_addr           (req_addr),
    .req_cmd            (req_cmd),
    .req_burst          (req_burst),
    .wdata              (wdata),
    .wdata_valid        (wdata_valid),
    .wdata_ready        (wdata_ready),
    .lut_address        (lut_address),
    .lut_path           (lut_path),
    .transaction_target (transaction_target),
    .failed_decoding    (failed_decoding),
    .flit_out           (flit_out),
    .flit_valid         (flit_valid),
    .flit_ready         (flit_ready),
    .flit_last          (flit_last),
    .err_valid          (err_valid),
    .err_ready          (err_ready),
    .err_cmd            (err_cmd)
  );

  always #5 clock = ~clock;

  task automatic printSummary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // One complete transaction. Entered and left at a negedge with the DUT idle.
  task automatic applyStimulus(input logic [31:0] addr, input logic [2:0] cmd,
                               input logic [7:0] burst, input logic [6:0] path,
                               input logic [3:0] tgt, input bit fail,
                               input bit stall, input logic [31:0] dataBase);
    int          burstN;
    bit          isWrite;
    logic [31:0] wq[$];
    logic [32:0] expQ[$];
    int          widx;
    int          firstValid;
    int          doneCyc;
    int          turn;
    bit          done;
    bit          errSeen;
    burstN     = (burst == 8'd0) ? 1 : int'(burst);
    isWrite    = (cmd == 3'd1);
    widx       = 0;
    firstValid = -1;
    doneCyc    = 0;
    done       = 1'b0;
    errSeen    = 1'b0;
    for (int i = 0; i < burstN; i++)
      wq.push_back((dataBase != 0) ? dataBase + 32'(i) : $urandom);
    if (!fail) begin
      expQ.push_back({1'b0, 6'b0, burstN[7:0], cmd, SRC, tgt, path});
      expQ.push_back({!isWrite, addr});
      if (isWrite)
        for (int i = 0; i < burstN; i++) expQ.push_back({(i == burstN - 1), wq[i]});
    end

    req_valid = 1'b1;
    req_addr  = addr;
    req_cmd   = cmd;
    req_burst = burst;
    checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_cmd   = 3'($urandom);
    req_burst = 8'($urandom);

    for (int cyc = 1; cyc <= MAXC && !done; cyc++) begin
      if (cyc == 1) begin
        lut_path           = path;
        transaction_target = tgt;
        failed_decoding    = fail;
      end else begin
        lut_path           = 7'($urandom);
        transaction_target = 4'($urandom);
        failed_decoding    = 1'($urandom);
      end
      flit_ready  = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      err_ready   = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      wdata_valid = (widx < burstN) && (stall ? ($urandom_range(0, 2) != 0) : 1'b1);
      wdata       = (widx < burstN) ? wq[widx] : $urandom;
      @(negedge clock);
      if (cyc == 1) checkOutput("lut_address", lut_address, addr);
      if (flit_valid) begin
        if (firstValid < 0) firstValid = cyc;
        if (expQ.size() == 0) checkOutput("unexpected_flit_valid", 32'(flit_valid), 32'd0);
        else begin
          checkOutput("flit_out", flit_out, expQ[0][31:0]);
          checkOutput("flit_last", 32'(flit_last), 32'(expQ[0][32]));
          if (flit_ready) void'(expQ.pop_front());
        end
      end
      if (wdata_valid && wdata_ready) widx++;
      if (err_valid) begin
        if (!fail) checkOutput("unexpected_err_valid", 32'(err_valid), 32'd0);
        else begin
          checkOutput("err_cmd", 32'(err_cmd), 32'(cmd));
          if (err_ready) errSeen = 1'b1;
        end
      end
      if (req_ready) begin
        done    = 1'b1;
        doneCyc = cyc;
      end else begin
        @(posedge clock); #1;
      end
    end

    checkOutput("txn_done", 32'(done), 32'd1);
    if (!done) begin
      printSummary();
      $finish;
    end
    checkOutput("flits_left", 32'(expQ.size()), 32'd0);
    checkOutput("beats_consumed", 32'(widx), isWrite ? 32'(burstN) : 32'd0);
    checkOutput("err_seen", 32'(errSeen), 32'(fail));
    if (!fail) checkOutput("hdr0_latency", 32'(firstValid), 32'd2);
    if (!stall) begin
      if (fail) turn = isWrite ? 3 + burstN : 3;
      else      turn = isWrite ? 4 + burstN : 4;
      checkOutput("turnaround", 32'(doneCyc), 32'(turn));
    end
  endtask

  initial begin
    reset              = 1'b1;
    req_valid          = 1'b0;
    req_addr           = '0;
    req_cmd            = '0;
    req_burst          = '0;
    wdata              = '0;
    wdata_valid        = 1'b0;
    lut_path           = '0;
    transaction_target = '0;
    failed_decoding    = 1'b0;
    flit_ready         = 1'b0;
    err_ready          = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_req_ready",   32'(req_ready),   32'd1);
    checkOutput("rst_flit_valid",  32'(flit_valid),  32'd0);
    checkOutput("rst_flit_last",   32'(flit_last),   32'd0);
    checkOutput("rst_wdata_ready", 32'(wdata_ready), 32'd0);
    checkOutput("rst_err_valid",   32'(err_valid),   32'd0);
    checkOutput("rst_flit_out",    flit_out,         32'd0);
    checkOutput("rst_lut_address", lut_address,      32'd0);
    checkOutput("rst_err_cmd",     32'(err_cmd),     32'd0);
    reset = 1'b0;

    $display("[TB] read burst 4, ready held high");
    applyStimulus(32'h1A00_0010, 3'd2, 8'd4, 7'h01, 4'hC, 1'b0, 1'b0, 32'h0);
    $display("[TB] write burst 3, data A/B/C");
    applyStimulus(32'h2000_0100, 3'd1, 8'd3, 7'h12, 4'h3, 1'b0, 1'b0, 32'hA);
    $display("[TB] write burst 3 with backpressure");
    applyStimulus(32'h2000_0200, 3'd1, 8'd3, 7'h35, 4'h7, 1'b0, 1'b1, 32'hA);
    $display("[TB] write with decode failure, burst 2");
    applyStimulus(32'h0000_1000, 3'd1, 8'd2, 7'h7F, 4'hF, 1'b1, 1'b0, 32'h0);
    $display("[TB] write with burst 0");
    applyStimulus(32'h3000_0004, 3'd1, 8'd0, 7'h44, 4'h2, 1'b0, 1'b0, 32'h55);
    $display("[TB] read with decode failure");
    applyStimulus(32'h0000_2000, 3'd2, 8'd5, 7'h00, 4'h0, 1'b1, 1'b0, 32'h0);
    $display("[TB] pass-through command code 5");
    applyStimulus(32'h4000_0008, 3'd5, 8'd2, 7'h21, 4'h9, 1'b0, 1'b0, 32'h0);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 24; t++) begin
      int          sel;
      logic [2:0]  c;
      sel = int'($urandom_range(0, 9));
      if (sel < 5)      c = 3'd1;
      else if (sel < 8) c = 3'd2;
      else              c = 3'($urandom);
      applyStimulus($urandom, c, 8'($urandom_range(0, 6)), 7'($urandom), 4'($urandom),
                    ($urandom_range(0, 4) == 0), 1'b1, 32'h0);
    end

    $display("[TB] reset during a 4-beat write burst");
    req_valid = 1'b1;
    req_addr  = 32'h5000_0040;
    req_cmd   = 3'd1;
    req_burst = 8'd4;
    @(posedge clock); #1;
    req_valid          = 1'b0;
    lut_path           = 7'h0A;
    transaction_target = 4'h5;
    failed_decoding    = 1'b0;
    flit_ready         = 1'b1;
    wdata_valid        = 1'b1;
    wdata              = 32'h1111_0001;
    repeat (3) begin
      @(posedge clock); #1;
    end
    @(negedge clock);
    checkOutput("mid_beat1_data", flit_out, 32'h1111_0001);
    checkOutput("mid_beat1_last", 32'(flit_last), 32'd0);
    @(posedge clock); #1;
    wdata = 32'h1111_0002;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("post_rst_flit_valid",  32'(flit_valid),  32'd0);
    checkOutput("post_rst_flit_last",   32'(flit_last),   32'd0);
    checkOutput("post_rst_req_ready",   32'(req_ready),   32'd1);
    checkOutput("post_rst_wdata_ready", 32'(wdata_ready), 32'd0);
    wdata_valid = 1'b0;

    $display("[TB] recovery read after reset");
    applyStimulus(32'h1A00_0010, 3'd2, 8'd1, 7'h03, 4'h1, 1'b0, 1'b0, 32'h0);

    printSummary();
    $finish;
  end

endmodule
